acia_rx: RTL and testbench
==========================

# acia_rx

Serial receive front end for the iceMCU UART: samples the asynchronous `RX` pin, reassembles 8N1 frames and buffers received bytes in a small FIFO for the 6502 peripheral bus. It is the receive-side counterpart of the MCU's serial transmitter and sits between the `RX` pad and the bus-side ACIA register decode. A single clock drives everything, and all state resets synchronously.

## Interface
Parameters:
- `DIVISOR`, 35: clock cycles per bit (4 MHz / 115200, rounded). Legal range 4..65535.
- `FIFO_DEPTH`, 4: receive FIFO entries. Must be a power of 2, at least 2.

Ports:
- `clk`  in  1: system clock, rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `RX`  in  1: asynchronous serial input. Idles high.
- `rx_data`  out  8: byte at the FIFO head. First-word fall-through.
- `rx_valid`  out  1: FIFO not empty.
- `rx_ready`  in  1: consumer pop. A pop occurs when `rx_valid && rx_ready`.
- `frame_err`  out  1: sticky. Set when a stop bit is sampled low.
- `overrun`  out  1: sticky. Set when a completed byte arrives with the FIFO full and no pop in that cycle.
- `clr_err`  in  1: clears `frame_err` and `overrun` on the next edge.

## Operation
- **Input synchronizer.** 2-flop synchronizer on `RX`. Both flops reset to 1. The FSM uses only the synchronized value `rxs`.
- **Bit counter.** Down-counter `cnt`, width `$clog2(DIVISOR)`.
- **Shift register.** 8-bit `sh`, filled LSB first, with bit index `bidx[2:0]`.
- **FSM states:**
  - IDLE: if `rxs==0`, load `cnt=DIVISOR/2-1` and go to START.
  - START: at `cnt==0`, sample. If `rxs==0`, load `cnt=DIVISOR-1`, set `bidx=0` and go to DATA. If `rxs==1`, the start bit was a glitch: go to IDLE with nothing recorded.
  - DATA: at `cnt==0`, shift `rxs` into `sh[7]` (right shift) and reload `cnt=DIVISOR-1`. After the sample with `bidx==7`, go to STOP; otherwise increment `bidx`.
  - STOP: at `cnt==0`, sample. If `rxs==1`, push `sh` into the FIFO and go to IDLE. If `rxs==0`, set `frame_err`, discard the byte and go to BREAK.
  - BREAK: stay until `rxs==1`, then go to IDLE. This prevents a held-low line from retriggering.
- **FIFO rules:**
  - Push when full: dropped, `overrun` set, contents unchanged.
  - Push and pop in the same cycle while full: the pop frees space and the push is accepted. No overrun.
  - Pop while empty: ignored.
  - Pointers are `$clog2(FIFO_DEPTH)+1` bits wide; the MSB distinguishes full from empty.
- **Error flags.** When `clr_err` and a new error event occur in the same cycle, the set wins.
- **Reset mid-frame.** FSM returns to IDLE, the FIFO empties, both flags clear and the synchronizer returns to 1. A partially received frame is lost.

## Timing
- **Reset values:** `rx_valid=0`, `rx_data=8'h00`, `frame_err=0`, `overrun=0`, FSM in IDLE, `cnt=0`.
- **Start detect.** The falling edge of `RX` reaches `rxs` 2 cycles later. IDLE leaves on the first cycle `rxs==0`.
- **Sample points.** Start-bit check at DIVISOR/2 cycles after detect; each later sample DIVISOR cycles after the previous one, i.e. mid-bit. The stop sample falls at nominally 9.5 bit-times after the start edge, plus the 2-cycle synchronizer delay.
- **Push latency.** `rx_valid` and `rx_data` update on the edge after the stop-sample cycle (1 cycle).
- **Pop latency.** After a pop, `rx_data` shows the next entry on the following edge. `rx_valid` falls on the same edge if the FIFO empties.
- **Error flags.** `frame_err` and `overrun` assert on the same edge as the would-be push.
- **Back-to-back frames.** Supported: the FSM is in IDLE about half a bit before the next start edge.
- **Baud tolerance.** At least ±3% between transmitter and `DIVISOR`.

## Structure
- **Shared package `acia_pkg`:** FSM state enum (IDLE, START, DATA, STOP, BREAK), the `FRAME_BITS=8` constant, and the default `DIVISOR` constant. The transmitter uses the same constant.
- **Sub-module `acia_rx_fifo`:** synchronous FWFT FIFO parameterized by width and depth. It reports push-dropped as an output, which drives `overrun`.

## Test plan
Bench uses `DIVISOR=8`, `FIFO_DEPTH=4` and a 4 MHz clock.
1. Send 0x55 then 0xA3, back to back, with `rx_ready=0` → `rx_valid` asserts 1 cycle after the first stop sample; popped bytes read 0x55, then 0xA3; flags stay 0.
2. RX low pulse of 3 cycles (shorter than DIVISOR/2) → start check sees 1, FSM back to IDLE, `rx_valid` stays 0, no flags.
3. Frame 0x3C sent with stop bit forced low, line held low 20 bit-times, then a valid 0x7E → `frame_err=1`, 0x3C not pushed, no retrigger during the low period, 0x7E received; `clr_err` → `frame_err=0`.
4. Five bytes 0x01..0x05 sent with no pops → FIFO holds 0x01..0x04, `overrun=1`. Repeat with `rx_ready` asserted in exactly the 5th push cycle → no overrun, FIFO holds 0x02..0x05.
5. Assert `reset` during bit 4 of a frame → all outputs at reset values on the next edge; a following clean 0xC9 is received correctly.
6. Send 0x96 with the bit period stretched to 8.24 cycles (+3%) → byte received as 0x96, no `frame_err`.

Source files
------------

// File: rtl/acia_pkg.sv
// Shared definitions for the ACIA serial blocks (receiver and transmitter).
`timescale 1ns/1ps
package acia_pkg;

    // Bits per character on the wire (8N1 data field).
    localparam int FRAME_BITS = 8;

    // Default clocks per bit: 4 MHz / 115200, rounded.
    localparam int DEFAULT_DIVISOR = 35;

    // Receiver frame-tracking states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

endpackage

// File: rtl/acia_rx_fifo.sv
// Small synchronous first-word-fall-through FIFO. The head entry is visible on
// head_data whenever not_empty is high. A push into a full FIFO is dropped and
// flagged unless a pop in the same cycle frees a slot.
`timescale 1ns/1ps
module acia_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             not_empty,
    output logic             push_dropped
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra MSB so full and empty are distinguishable.
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [WIDTH-1:0] mem_reg [DEPTH];

    logic empty;
    logic full;
    logic pop_en;
    logic push_en;

    // Occupancy decode and push/pop qualification.
    always_comb begin
        empty        = (wr_ptr_reg == rd_ptr_reg);
        full         = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                       (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
        pop_en       = pop && !empty;
        // A simultaneous pop frees the slot the push needs.
        push_en      = push && (!full || pop_en);
        push_dropped = push && full && !pop_en;
        not_empty    = !empty;
        head_data    = mem_reg[rd_ptr_reg[AW-1:0]];
    end

    // Read/write pointer update.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_en)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Storage: entries clear on reset so the head reads zero while empty.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            // Write one entry when it is the current write slot.
            always_ff @(posedge clk) begin
                if (srst) begin
                    mem_reg[gi] <= '0;
                end else if (push_en && (wr_ptr_reg[AW-1:0] == AW'(gi))) begin
                    mem_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/acia_rx.sv
// UART receive front end: synchronizes RX, reassembles 8N1 frames with
// mid-bit sampling, and buffers bytes in a FWFT FIFO with sticky
// framing-error and overrun flags.
`timescale 1ns/1ps
module acia_rx
    import acia_pkg::*;
#(
    parameter int DIVISOR    = DEFAULT_DIVISOR,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RX,
    output logic [FRAME_BITS-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  frame_err,
    output logic                  overrun,
    input  logic                  clr_err
);

    localparam int CW = $clog2(DIVISOR);
    localparam int BW = $clog2(FRAME_BITS);
    localparam logic [CW-1:0] HALF_LOAD = CW'(DIVISOR / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(DIVISOR - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(FRAME_BITS - 1);

    logic rx_meta_reg;
    logic rxs_reg;

    rx_state_t             state_reg, state_next;
    logic [CW-1:0]         cnt_reg, cnt_next;
    logic [BW-1:0]         bidx_reg, bidx_next;
    logic [FRAME_BITS-1:0] sh_reg, sh_next;

    logic byte_push;
    logic frame_evt;
    logic push_dropped;
    logic frame_err_reg;
    logic overrun_reg;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_reg <= 1'b1;
            rxs_reg     <= 1'b1;
        end else begin
            rx_meta_reg <= RX;
            rxs_reg     <= rx_meta_reg;
        end
    end

    // FSM state and frame datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            bidx_reg  <= '0;
            sh_reg    <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            bidx_reg  <= bidx_next;
            sh_reg    <= sh_next;
        end
    end

    // Next-state decision: samples are taken only when the counter hits zero.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (!rxs_reg) state_next = START;
            START: if (cnt_reg == '0) state_next = rxs_reg ? IDLE : DATA;
            DATA:  if (cnt_reg == '0 && bidx_reg == LAST_BIT) state_next = STOP;
            STOP:  if (cnt_reg == '0) state_next = rxs_reg ? IDLE : BREAK;
            // Held-low line must return high before a new start is accepted.
            BREAK: if (rxs_reg) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Per-state datapath updates and the push / framing-error strobes.
    always_comb begin
        cnt_next  = cnt_reg;
        bidx_next = bidx_reg;
        sh_next   = sh_reg;
        byte_push = 1'b0;
        frame_evt = 1'b0;
        case (state_reg)
            IDLE: begin
                // Half-bit load puts the start check at mid start bit.
                if (!rxs_reg) cnt_next = HALF_LOAD;
            end
            START: begin
                if (cnt_reg == '0) begin
                    if (!rxs_reg) begin
                        cnt_next  = FULL_LOAD;
                        bidx_next = '0;
                    end
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            DATA: begin
                if (cnt_reg == '0) begin
                    // LSB arrives first, so shift right from the top.
                    sh_next  = {rxs_reg, sh_reg[FRAME_BITS-1:1]};
                    cnt_next = FULL_LOAD;
                    if (bidx_reg != LAST_BIT) bidx_next = bidx_reg + 1'b1;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            STOP: begin
                if (cnt_reg == '0) begin
                    if (rxs_reg) byte_push = 1'b1;
                    else         frame_evt = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Sticky error flags; a new event in the clearing cycle keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            if (frame_evt)    frame_err_reg <= 1'b1;
            else if (clr_err) frame_err_reg <= 1'b0;
            if (push_dropped) overrun_reg <= 1'b1;
            else if (clr_err) overrun_reg <= 1'b0;
        end
    end

    acia_rx_fifo #(
        .WIDTH (FRAME_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .srst         (reset),
        .push         (byte_push),
        .push_data    (sh_reg),
        .pop          (rx_ready),
        .head_data    (rx_data),
        .not_empty    (rx_valid),
        .push_dropped (push_dropped)
    );

    assign frame_err = frame_err_reg;
    assign overrun   = overrun_reg;

endmodule

// File: tb/tb_acia_rx.sv
// Bench for acia_rx with DIVISOR=8 and a 4 MHz clock. Expected bytes go into
// a queue when frames are sent; a negedge monitor checks each popped byte.
`timescale 1ns/1ps
module tb_acia_rx;

    localparam int DIV = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       RX = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       frame_err;
    logic       overrun;
    logic       clr_err = 1'b0;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [7:0] exp_q [$];

    acia_rx #(.DIVISOR(DIV), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .RX        (RX),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .clr_err   (clr_err)
    );

    always #125 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
            $display("check %s: got %02h ok", name, act);
        end else begin
            $display("FAIL %s: got %02h, expected %02h", name, act, exp);
        end
    endtask

    // Monitor: every cycle that will pop is compared against the scoreboard.
    always @(negedge clk) begin
        if (!reset && rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL pop_unexpected: got %02h, expected no data", rx_data);
            end else begin
                check("pop_data", rx_data, exp_q.pop_front());
            end
        end
    end

    // Nominal 8N1 frame, bit edges 1 ns after a rising clock edge.
    task automatic send_frame(input logic [7:0] b, input logic stop_val);
        @(posedge clk); #1 RX = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (DIV) @(posedge clk);
            #1 RX = b[i];
        end
        repeat (DIV) @(posedge clk);
        #1 RX = stop_val;
        repeat (DIV) @(posedge clk);
        #1;
    endtask

    // Frame with an arbitrary real bit period in ns.
    task automatic send_frame_ns(input logic [7:0] b, input real bit_ns);
        @(posedge clk); #1 RX = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            #(bit_ns);
        end
        RX = 1'b1;
        #(bit_ns);
    endtask

    // Pop until the scoreboard is empty, bounded.
    task automatic drain();
        int t = 0;
        @(posedge clk); #1 rx_ready = 1'b1;
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        #1 rx_ready = 1'b0;
        if (t >= 100) begin
            total_cnt++;
            $display("FAIL drain_timeout: %0d bytes still expected, expected 0", exp_q.size());
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1 clr_err = 1'b1;
        @(posedge clk); #1 clr_err = 1'b0;
    endtask

    initial begin
        idle(3);
        check("reset_valid", {7'd0, rx_valid}, 8'd0);
        check("reset_data", rx_data, 8'h00);
        check("reset_ferr", {7'd0, frame_err}, 8'd0);
        check("reset_ovr", {7'd0, overrun}, 8'd0);
        #1 reset = 1'b0;
        idle(4);

        // 1: back-to-back 0x55, 0xA3 with push-latency timing check.
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hA3);
        fork
            send_frame(8'h55, 1'b1);
            begin
                @(posedge clk);
                repeat (78) @(posedge clk);
                #1 check("t1_valid_before_push", {7'd0, rx_valid}, 8'd0);
                @(posedge clk);
                #1 check("t1_valid_after_push", {7'd0, rx_valid}, 8'd1);
            end
        join
        send_frame(8'hA3, 1'b1);
        idle(4);
        check("t1_ferr", {7'd0, frame_err}, 8'd0);
        check("t1_ovr", {7'd0, overrun}, 8'd0);
        drain();
        check("t1_empty", {7'd0, rx_valid}, 8'd0);

        // 2: 3-cycle glitch on RX.
        @(posedge clk); #1 RX = 1'b0;
        idle(3);
        RX = 1'b1;
        idle(20);
        check("t2_valid", {7'd0, rx_valid}, 8'd0);
        check("t2_ferr", {7'd0, frame_err}, 8'd0);

        // 3: bad stop bit, long break, then a clean 0x7E.
        send_frame(8'h3C, 1'b0);
        idle(20 * DIV);
        RX = 1'b1;
        idle(2 * DIV);
        check("t3_ferr_set", {7'd0, frame_err}, 8'd1);
        check("t3_no_push", {7'd0, rx_valid}, 8'd0);
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1);
        idle(4);
        check("t3_ferr_sticky", {7'd0, frame_err}, 8'd1);
        drain();
        pulse_clr();
        check("t3_ferr_clr", {7'd0, frame_err}, 8'd0);
        check("t3_ovr", {7'd0, overrun}, 8'd0);

        // 4a: five bytes into a 4-deep FIFO, no pops.
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b1);
        end
        idle(4);
        check("t4a_ovr_set", {7'd0, overrun}, 8'd1);
        check("t4a_head", rx_data, 8'h01);
        drain();
        check("t4a_empty", {7'd0, rx_valid}, 8'd0);
        pulse_clr();
        check("t4a_ovr_clr", {7'd0, overrun}, 8'd0);

        // 4b: same, popping exactly in the fifth push cycle.
        for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
        fork
            send_frame(8'h05, 1'b1);
            begin
                @(posedge clk);
                repeat (78) @(posedge clk);
                #1 rx_ready = 1'b1;
                @(posedge clk);
                #1 rx_ready = 1'b0;
            end
        join
        idle(4);
        check("t4b_ovr", {7'd0, overrun}, 8'd0);
        check("t4b_head", rx_data, 8'h02);
        drain();
        check("t4b_empty", {7'd0, rx_valid}, 8'd0);

        // 5: reset in the middle of bit 4, with data and a flag pending.
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b0);
        idle(2 * DIV);
        RX = 1'b1;
        idle(2 * DIV);
        check("t5_pre_valid", {7'd0, rx_valid}, 8'd1);
        check("t5_pre_ferr", {7'd0, frame_err}, 8'd1);
        fork
            send_frame(8'hF0, 1'b1);
            begin
                @(posedge clk);
                repeat (44) @(posedge clk);
                #1 reset = 1'b1;
                @(posedge clk);
                #1;
                check("t5_rst_valid", {7'd0, rx_valid}, 8'd0);
                check("t5_rst_data", rx_data, 8'h00);
                check("t5_rst_ferr", {7'd0, frame_err}, 8'd0);
                check("t5_rst_ovr", {7'd0, overrun}, 8'd0);
                reset = 1'b0;
            end
        join
        idle(2 * DIV);
        check("t5_no_partial", {7'd0, rx_valid}, 8'd0);
        exp_q.push_back(8'hC9);
        send_frame(8'hC9, 1'b1);
        idle(4);
        drain();
        check("t5_ferr", {7'd0, frame_err}, 8'd0);

        // 6: +3% slow transmitter.
        exp_q.push_back(8'h96);
        send_frame_ns(8'h96, 2060.0);
        idle(4);
        check("t6_valid", {7'd0, rx_valid}, 8'd1);
        drain();
        check("t6_ferr", {7'd0, frame_err}, 8'd0);
        check("t6_empty", {7'd0, rx_valid}, 8'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
